// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage.
//
// Consumes the EX/MEM pipeline register, runs word loads/stores as a bus
// master (request/grant/ready, all active low) and drives busy while an
// access is in flight. The stage result goes out combinationally on
// fwd_data and is registered into the MEM/WB pipeline register.
//
// Build option:
//   MEM_ALIGN_CHECK_EN  when defined, LDW/STW with ex_out[1:0] != 0 raise
//                       exception code 4 and perform no bus access. When
//                       undefined, the low address bits are ignored.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall, flush          pipeline hold / bubble insert for MEM/WB
//   busy                  stall request to pipeline control
//   fwd_data              unregistered stage result for forwarding
//   ex_*                  EX/MEM pipeline register contents
//   bus_*                 shared bus master interface
//   mem_*                 MEM/WB pipeline register
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] fwd_data,
    input  logic [29:0] ex_pc,
    input  logic        ex_en,
    input  logic        ex_br_flag,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wr_data,
    input  logic [1:0]  ex_ctrl_op,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_we_,
    input  logic [2:0]  ex_exp_code,
    input  logic [31:0] ex_out,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_,
    input  logic        bus_grnt_,
    output logic        bus_req_,
    output logic [29:0] bus_addr,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [31:0] bus_wr_data,
    output logic [29:0] mem_pc,
    output logic        mem_en,
    output logic        mem_br_flag,
    output logic [1:0]  mem_ctrl_op,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_we_,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out
);

    localparam logic [1:0] MemOpLdw     = 2'd1;
    localparam logic [1:0] MemOpStw     = 2'd2;
    localparam logic [2:0] ExpMissAlign = 3'd4;

    typedef enum logic [1:0] {StIdle, StReq, StAccess, StStall} state_e;

    state_e      state_q, state_d;
    logic [31:0] rd_buf_q;
    logic [29:0] addr_q;
    logic        rw_q;
    logic [31:0] wr_data_q;

    logic        is_mem;
    logic        miss_align;
    logic        acc;
    logic        latch_req;
    logic        rd_buf_we;
    logic [31:0] rd_data;
    logic [31:0] result;

    always_comb begin
        is_mem = (ex_mem_op == MemOpLdw) || (ex_mem_op == MemOpStw);
`ifdef MEM_ALIGN_CHECK_EN
        miss_align = is_mem && (ex_out[1:0] != 2'b00);
`else
        miss_align = 1'b0;
`endif
        acc = ex_en && (ex_exp_code == 3'd0) && is_mem && !miss_align;
    end

    // Bus FSM: outputs are decoded from the state; address/direction/data are
    // captured at grant so they stay stable through the ACCESS wait.
    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        bus_req_    = 1'b1;
        bus_as_     = 1'b1;
        bus_rw      = 1'b1;
        bus_addr    = 30'd0;
        bus_wr_data = 32'd0;
        rd_data     = 32'd0;
        latch_req   = 1'b0;
        rd_buf_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (acc && !flush) begin
                    bus_req_ = 1'b0;
                    busy     = 1'b1;
                    state_d  = StReq;
                end
            end
            StReq: begin
                bus_req_ = 1'b0;
                busy     = 1'b1;
                if (!bus_grnt_) begin
                    bus_as_     = 1'b0;
                    bus_addr    = ex_out[31:2];
                    bus_rw      = (ex_mem_op == MemOpLdw);
                    bus_wr_data = ex_mem_wr_data;
                    latch_req   = 1'b1;
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                bus_req_    = 1'b0;
                bus_addr    = addr_q;
                bus_rw      = rw_q;
                bus_wr_data = wr_data_q;
                if (bus_rdy_) begin
                    busy = 1'b1;
                end else begin
                    rd_data   = bus_rd_data;
                    rd_buf_we = 1'b1;
                    state_d   = stall ? StStall : StIdle;
                end
            end
            StStall: begin
                // Pipeline is held externally; replay the captured load data.
                rd_data = rd_buf_q;
                if (!stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        result   = (ex_mem_op == MemOpLdw) ? rd_data : ex_out;
        fwd_data = result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rd_buf_q  <= 32'd0;
            addr_q    <= 30'd0;
            rw_q      <= 1'b1;
            wr_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (rd_buf_we) begin
                rd_buf_q <= bus_rd_data;
            end
            if (latch_req) begin
                addr_q    <= ex_out[31:2];
                rw_q      <= (ex_mem_op == MemOpLdw);
                wr_data_q <= ex_mem_wr_data;
            end
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_pc       <= 30'd0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= 2'd0;
            mem_dst_addr <= 5'd0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= 3'd0;
            mem_out      <= 32'd0;
        end else if (!stall) begin
            if (flush) begin
                mem_pc       <= 30'd0;
                mem_en       <= 1'b0;
                mem_br_flag  <= 1'b0;
                mem_ctrl_op  <= 2'd0;
                mem_dst_addr <= 5'd0;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= 3'd0;
                mem_out      <= 32'd0;
            end else if (miss_align) begin
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= 1'b0;
                mem_ctrl_op  <= 2'd0;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= ExpMissAlign;
                mem_out      <= 32'd0;
            end else begin
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= ex_ctrl_op;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= ex_gpr_we_;
                mem_exp_code <= ex_exp_code;
                mem_out      <= result;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset, flush, ext_stall, stall;
    logic        busy;
    logic [31:0] fwd_data;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag, ex_gpr_we_;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [4:0]  ex_dst_addr;
    logic [2:0]  ex_exp_code;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_, bus_grnt_;
    logic        bus_req_, bus_as_, bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Pipeline control: the stage's own stall request plus an external stall.
    assign stall = busy | ext_stall;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .busy           (busy),
        .fwd_data       (fwd_data),
        .ex_pc          (ex_pc),
        .ex_en          (ex_en),
        .ex_br_flag     (ex_br_flag),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_ctrl_op     (ex_ctrl_op),
        .ex_dst_addr    (ex_dst_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_exp_code    (ex_exp_code),
        .ex_out         (ex_out),
        .bus_rd_data    (bus_rd_data),
        .bus_rdy_       (bus_rdy_),
        .bus_grnt_      (bus_grnt_),
        .bus_req_       (bus_req_),
        .bus_addr       (bus_addr),
        .bus_as_        (bus_as_),
        .bus_rw         (bus_rw),
        .bus_wr_data    (bus_wr_data),
        .mem_pc         (mem_pc),
        .mem_en         (mem_en),
        .mem_br_flag    (mem_br_flag),
        .mem_ctrl_op    (mem_ctrl_op),
        .mem_dst_addr   (mem_dst_addr),
        .mem_gpr_we_    (mem_gpr_we_),
        .mem_exp_code   (mem_exp_code),
        .mem_out        (mem_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [29:0] pc, input logic [1:0] op, input logic [31:0] out,
                          input logic [31:0] wd, input logic [4:0] dst, input logic we_);
        ex_pc          = pc;
        ex_en          = 1'b1;
        ex_br_flag     = 1'b0;
        ex_mem_op      = op;
        ex_mem_wr_data = wd;
        ex_ctrl_op     = 2'd0;
        ex_dst_addr    = dst;
        ex_gpr_we_     = we_;
        ex_exp_code    = 3'd0;
        ex_out         = out;
    endtask

    // Bus slave: grants after gw waiting REQ cycles, readies after rw waiting
    // ACCESS cycles. sw > 0 holds the external stall on the ready cycle and sw
    // cycles more. Returns at posedge+1 after the MEM/WB register has loaded.
    task automatic run_access(input int gw, input int rw, input int sw,
                              input logic [31:0] rdat, input int flush_at,
                              output int n_busy, output int n_as,
                              output logic [29:0] a_addr, output logic a_rw,
                              output logic [31:0] a_wd);
        int req_cyc = 0;
        int acc_cyc = 0;
        int n_cyc   = 0;
        bit granted = 0;
        bit done    = 0;
        n_busy = 0;
        n_as   = 0;
        a_addr = '0;
        a_rw   = 1'b0;
        a_wd   = '0;
        while (!done && n_cyc < 50) begin
            if (flush_at >= 0 && n_cyc == flush_at) flush = 1'b1;
            bus_grnt_   = !(!granted && req_cyc >= gw + 1);
            bus_rdy_    = !(granted && acc_cyc >= rw);
            bus_rd_data = (granted && acc_cyc >= rw) ? rdat : 32'hFFFF0000;
            ext_stall   = granted && acc_cyc >= rw && sw > 0;
            @(negedge clk);
            if (busy) n_busy++;
            if (!bus_as_) begin
                n_as++;
                a_addr = bus_addr;
                a_rw   = bus_rw;
                a_wd   = bus_wr_data;
            end
            if (granted && !bus_rdy_) done = 1;
            if (!bus_req_ && !granted) req_cyc++;
            if (granted) acc_cyc++;
            if (!bus_as_) granted = 1;
            next_cycle();
            n_cyc++;
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
        bus_grnt_   = 1'b1;
        bus_rdy_    = 1'b1;
        bus_rd_data = 32'h12121212;
        for (int i = 0; i < sw; i++) begin
            bus_rd_data = 32'h12121212 + 32'(i);
            @(negedge clk);
            check("stall_busy", 32'(busy), 32'd0);
            check("stall_req", 32'(bus_req_), 32'd1);
            next_cycle();
        end
        if (sw > 0) begin
            ext_stall = 1'b0;
            next_cycle();
        end
    endtask

    int          nb, na;
    logic [29:0] aa;
    logic        ar;
    logic [31:0] aw;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; ext_stall = 1'b0;
        set_ex(30'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        ex_en = 1'b0;
        bus_rd_data = 32'd0; bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_gpr_we_", 32'(mem_gpr_we_), 32'd1);
        check("rst_mem_out", mem_out, 32'd0);
        check("rst_mem_pc", 32'(mem_pc), 32'd0);
        check("rst_bus_req_", 32'(bus_req_), 32'd1);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_rw", 32'(bus_rw), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        next_cycle();

        // Non-memory op passes straight through in one cycle
        set_ex(30'h111, 2'd0, 32'h12345678, 32'd0, 5'd3, 1'b0);
        ex_br_flag = 1'b1; ex_ctrl_op = 2'd2;
        @(negedge clk);
        check("nop_busy", 32'(busy), 32'd0);
        check("nop_req_", 32'(bus_req_), 32'd1);
        check("nop_fwd", fwd_data, 32'h12345678);
        next_cycle();
        check("nop_mem_out", mem_out, 32'h12345678);
        check("nop_mem_pc", 32'(mem_pc), 32'h111);
        check("nop_dst", 32'(mem_dst_addr), 32'd3);
        check("nop_we_", 32'(mem_gpr_we_), 32'd0);
        check("nop_br", 32'(mem_br_flag), 32'd1);
        check("nop_ctrl", 32'(mem_ctrl_op), 32'd2);
        check("nop_en", 32'(mem_en), 32'd1);

        // Reserved op behaves as NOP, low address bits irrelevant
        set_ex(30'h112, 2'd3, 32'hA5A50003, 32'd0, 5'd1, 1'b0);
        @(negedge clk);
        check("rsv_busy", 32'(busy), 32'd0);
        check("rsv_req_", 32'(bus_req_), 32'd1);
        next_cycle();
        check("rsv_mem_out", mem_out, 32'hA5A50003);
        check("rsv_exp", 32'(mem_exp_code), 32'd0);

        // External stall holds MEM/WB
        ext_stall = 1'b1;
        set_ex(30'h113, 2'd0, 32'h0BADF00D, 32'd0, 5'd1, 1'b0);
        next_cycle();
        check("hold_mem_out", mem_out, 32'hA5A50003);
        ext_stall = 1'b0;

        // Flush loads a bubble
        flush = 1'b1;
        next_cycle();
        check("flush_mem_out", mem_out, 32'd0);
        check("flush_we_", 32'(mem_gpr_we_), 32'd1);
        check("flush_en", 32'(mem_en), 32'd0);
        flush = 1'b0;

        // LDW, immediate grant and ready
        set_ex(30'h200, 2'd1, 32'h00000100, 32'd0, 5'd7, 1'b0);
        run_access(0, 0, 0, 32'hDEADBEEF, -1, nb, na, aa, ar, aw);
        check("ldw_busy_cycles", 32'(nb), 32'd2);
        check("ldw_as_pulses", 32'(na), 32'd1);
        check("ldw_addr", 32'(aa), 32'h40);
        check("ldw_rw", 32'(ar), 32'd1);
        check("ldw_mem_out", mem_out, 32'hDEADBEEF);
        check("ldw_dst", 32'(mem_dst_addr), 32'd7);
        check("ldw_we_", 32'(mem_gpr_we_), 32'd0);

        // STW, grant after 3 waits, ready after 2 waits
        set_ex(30'h201, 2'd2, 32'h00000204, 32'hCAFEF00D, 5'd9, 1'b1);
        run_access(3, 2, 0, 32'h0, -1, nb, na, aa, ar, aw);
        check("stw_busy_cycles", 32'(nb), 32'd7);
        check("stw_as_pulses", 32'(na), 32'd1);
        check("stw_addr", 32'(aa), 32'h81);
        check("stw_rw", 32'(ar), 32'd0);
        check("stw_wdata", aw, 32'hCAFEF00D);
        check("stw_we_", 32'(mem_gpr_we_), 32'd1);
        check("stw_mem_out", mem_out, 32'h00000204);

        // LDW ready under external stall: data buffered until stall drops
        set_ex(30'h202, 2'd1, 32'h00000300, 32'd0, 5'd4, 1'b0);
        run_access(0, 0, 2, 32'h55AA55AA, -1, nb, na, aa, ar, aw);
        check("stl_busy_cycles", 32'(nb), 32'd2);
        check("stl_addr", 32'(aa), 32'hC0);
        check("stl_mem_out", mem_out, 32'h55AA55AA);

        // Flush raised in REQ: transaction completes, register gets a bubble
        set_ex(30'h203, 2'd1, 32'h00000400, 32'd0, 5'd6, 1'b0);
        run_access(1, 1, 0, 32'h13579BDF, 1, nb, na, aa, ar, aw);
        flush = 1'b0;
        check("fl_as_pulses", 32'(na), 32'd1);
        check("fl_busy_cycles", 32'(nb), 32'd4);
        check("fl_mem_out", mem_out, 32'd0);
        check("fl_we_", 32'(mem_gpr_we_), 32'd1);
        check("fl_en", 32'(mem_en), 32'd0);

        // Misaligned LDW
        set_ex(30'h204, 2'd1, 32'h00000102, 32'd0, 5'd2, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        check("mis_busy", 32'(busy), 32'd0);
        check("mis_req_", 32'(bus_req_), 32'd1);
        next_cycle();
        check("mis_exp", 32'(mem_exp_code), 32'd4);
        check("mis_we_", 32'(mem_gpr_we_), 32'd1);
        check("mis_mem_out", mem_out, 32'd0);
        check("mis_pc", 32'(mem_pc), 32'h204);
`else
        run_access(0, 0, 0, 32'h600DCAFE, -1, nb, na, aa, ar, aw);
        check("mis_addr", 32'(aa), 32'h40);
        check("mis_mem_out", mem_out, 32'h600DCAFE);
        check("mis_exp", 32'(mem_exp_code), 32'd0);
`endif

        // Reset while waiting in ACCESS
        set_ex(30'h205, 2'd1, 32'h00000500, 32'd0, 5'd5, 1'b0);
        bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b1; ex_en = 1'b0;
        @(negedge clk);
        check("rstacc_busy_before", 32'(busy), 32'd1);
        next_cycle();
        reset = 1'b0; bus_grnt_ = 1'b1;
        @(negedge clk);
        check("rstacc_req_", 32'(bus_req_), 32'd1);
        check("rstacc_as_", 32'(bus_as_), 32'd1);
        check("rstacc_addr", 32'(bus_addr), 32'd0);
        check("rstacc_busy", 32'(busy), 32'd0);
        check("rstacc_mem_out", mem_out, 32'd0);
        check("rstacc_we_", 32'(mem_gpr_we_), 32'd1);
        check("rstacc_pc", 32'(mem_pc), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
